// File: rtl/pacman_pkg.sv
// Shared game constants: state encoding, tile index width, BCD score layout and
// the default maze dot count.
package pacman_pkg;

    localparam int TILE_IDX_W    = 10;
    localparam int BCD_DIGITS    = 4;
    localparam int DOT_TOTAL_DEF = 150;
    localparam int SCORE_W       = 4 * BCD_DIGITS;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {BCD_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with carry in/out; chained to build the score adder.
module bcd_digit_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);

    logic [4:0] raw;

    always_comb begin
        raw   = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
        c_o   = (raw > 5'd9);
        // modulo-16 wrap of the low nibble makes the -10 correction exact
        sum_o = c_o ? (raw[3:0] - 4'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Game progress tracker: score, dots, lives, level and the IDLE/PLAYING/CLEAR/OVER
// flow. Optional extra life at 1000 points is enabled by defining EXTRA_LIFE_EN.
module score_keeper
    import pacman_pkg::*;
#(
    parameter int DOT_TOTAL    = DOT_TOTAL_DEF,
    parameter int DOT_POINTS   = 1,
    parameter int CLEAR_CYCLES = 120,
    parameter int START_LIVES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  eat_valid,
    input  logic [TILE_IDX_W-1:0] eat_tile_idx,
    input  logic                  player_caught,
    output logic [SCORE_W-1:0]    score_bcd,
    output logic [7:0]            dots_left,
    output logic [1:0]            lives,
    output logic [3:0]            level,
    output logic [1:0]            game_state,
    output logic                  dot_reload
);

    localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [7:0]       DOTS_INIT  = 8'(DOT_TOTAL);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0]       DIGIT_PTS  = 4'(DOT_POINTS);

    game_state_e             state_q;
    logic [SCORE_W-1:0]      score_q, score_d, score_sum;
    logic [7:0]              dots_q;
    logic [1:0]              lives_q, lives_eat, lives_d;
    logic [3:0]              level_q;
    logic                    reload_q;
    logic [CNT_W-1:0]        clr_cnt_q;
    logic                    last_vld_q;
    logic [TILE_IDX_W-1:0]   last_idx_q;
    logic                    accept, last_dot, caught;
    logic [BCD_DIGITS:1]     carry;

    // Ones digit never changes; points enter at the tens digit and ripple up.
    assign carry[1]        = 1'b0;
    assign score_sum[3:0]  = score_q[3:0];

    for (genvar g = 1; g < BCD_DIGITS; g++) begin : g_digit
        bcd_digit_add u_add (
            .a_i   (score_q[4*g +: 4]),
            .b_i   ((g == 1) ? DIGIT_PTS : 4'd0),
            .c_i   (carry[g]),
            .sum_o (score_sum[4*g +: 4]),
            .c_o   (carry[g+1])
        );
    end

    assign score_d = carry[BCD_DIGITS] ? SCORE_MAX : score_sum;

    always_comb begin
        accept   = (state_q == ST_PLAYING) && eat_valid &&
                   !(last_vld_q && (last_idx_q == eat_tile_idx));
        last_dot = accept && (dots_q == 8'd1);
        // emptying the maze takes precedence over a same-cycle catch
        caught   = (state_q == ST_PLAYING) && player_caught && !last_dot;
    end

`ifdef EXTRA_LIFE_EN
    logic award_q, award;
    assign award     = accept && !award_q &&
                       (score_q[SCORE_W-1:12] == '0) && (score_d[SCORE_W-1:12] != '0);
    assign lives_eat = (award && (lives_q != 2'd3)) ? lives_q + 2'd1 : lives_q;
`else
    assign lives_eat = lives_q;
`endif

    assign lives_d = caught ? lives_eat - 2'd1 : lives_eat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            dots_q     <= DOTS_INIT;
            lives_q    <= LIVES_INIT;
            level_q    <= 4'd1;
            reload_q   <= 1'b0;
            clr_cnt_q  <= '0;
            last_vld_q <= 1'b0;
            last_idx_q <= '0;
`ifdef EXTRA_LIFE_EN
            award_q    <= 1'b0;
`endif
        end else begin
            reload_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q    <= ST_PLAYING;
                        score_q    <= '0;
                        dots_q     <= DOTS_INIT;
                        lives_q    <= LIVES_INIT;
                        level_q    <= 4'd1;
                        reload_q   <= 1'b1;
                        clr_cnt_q  <= '0;
                        last_vld_q <= 1'b0;
`ifdef EXTRA_LIFE_EN
                        award_q    <= 1'b0;
`endif
                    end
                end
                ST_PLAYING: begin
                    if (accept) begin
                        score_q    <= score_d;
                        dots_q     <= dots_q - 8'd1;
                        last_vld_q <= 1'b1;
                        last_idx_q <= eat_tile_idx;
                    end
`ifdef EXTRA_LIFE_EN
                    if (award) award_q <= 1'b1;
`endif
                    lives_q <= lives_d;
                    if (last_dot) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end else if (caught && (lives_eat == 2'd1)) begin
                        state_q <= ST_OVER;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CNT_LAST) begin
                        state_q    <= ST_PLAYING;
                        clr_cnt_q  <= '0;
                        dots_q     <= DOTS_INIT;
                        level_q    <= (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                        reload_q   <= 1'b1;
                        last_vld_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign score_bcd  = score_q;
    assign dots_left  = dots_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign game_state = state_q;
    assign dot_reload = reload_q;

endmodule

// File: tb/tb_score_keeper.sv
// Two score_keeper instances on shared stimulus, checked every cycle against an
// integer-arithmetic game model, plus literal checks for the key scenarios.
module tb_score_keeper;

    localparam int A_TOTAL = 150, A_PTS = 1, A_CLR = 8, A_LIVES = 3;
    localparam int B_TOTAL = 2,   B_PTS = 9, B_CLR = 5, B_LIVES = 2;
`ifdef EXTRA_LIFE_EN
    localparam bit EXTRA = 1'b1;
`else
    localparam bit EXTRA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0, st = 1'b0, ev = 1'b0, pc = 1'b0;
    logic [9:0] idx = '0;

    logic [15:0] a_score, b_score;
    logic [7:0]  a_dots, b_dots;
    logic [1:0]  a_lives, b_lives, a_state, b_state;
    logic [3:0]  a_level, b_level;
    logic        a_rl, b_rl;

    always #5 clk = ~clk;

    score_keeper #(.DOT_TOTAL(A_TOTAL), .DOT_POINTS(A_PTS), .CLEAR_CYCLES(A_CLR),
                   .START_LIVES(A_LIVES)) dut_a (
        .clk(clk), .reset(rst), .start(st), .eat_valid(ev), .eat_tile_idx(idx),
        .player_caught(pc), .score_bcd(a_score), .dots_left(a_dots), .lives(a_lives),
        .level(a_level), .game_state(a_state), .dot_reload(a_rl));

    score_keeper #(.DOT_TOTAL(B_TOTAL), .DOT_POINTS(B_PTS), .CLEAR_CYCLES(B_CLR),
                   .START_LIVES(B_LIVES)) dut_b (
        .clk(clk), .reset(rst), .start(st), .eat_valid(ev), .eat_tile_idx(idx),
        .player_caught(pc), .score_bcd(b_score), .dots_left(b_dots), .lives(b_lives),
        .level(b_level), .game_state(b_state), .dot_reload(b_rl));

    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;
    int rl_cnt = 0;

    // model state: 0 IDLE, 1 PLAYING, 2 CLEAR, 3 OVER; score kept as a decimal integer
    int m_state[2], m_score[2], m_dots[2], m_lives[2], m_level[2], m_cnt[2], m_lasti[2];
    bit m_reload[2], m_lastv[2], m_award[2];

    function automatic int p_total(int k); return (k == 0) ? A_TOTAL : B_TOTAL; endfunction
    function automatic int p_pts(int k);   return (k == 0) ? A_PTS   : B_PTS;   endfunction
    function automatic int p_clr(int k);   return (k == 0) ? A_CLR   : B_CLR;   endfunction
    function automatic int p_lives(int k); return (k == 0) ? A_LIVES : B_LIVES; endfunction

    function automatic int to_bcd(int v);
        return (v % 10) | (((v / 10) % 10) << 4) | (((v / 100) % 10) << 8) | (((v / 1000) % 10) << 12);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit emptied;
            int old;
            emptied = 1'b0;
            if (rst) begin
                m_state[k] = 0; m_score[k] = 0; m_dots[k] = p_total(k);
                m_lives[k] = p_lives(k); m_level[k] = 1; m_reload[k] = 1'b0;
                m_cnt[k] = 0; m_lastv[k] = 1'b0; m_award[k] = 1'b0;
            end else begin
                m_reload[k] = 1'b0;
                case (m_state[k])
                    0, 3: if (st) begin
                        m_state[k] = 1; m_score[k] = 0; m_dots[k] = p_total(k);
                        m_lives[k] = p_lives(k); m_level[k] = 1; m_reload[k] = 1'b1;
                        m_lastv[k] = 1'b0; m_award[k] = 1'b0;
                    end
                    1: begin
                        if (ev && !(m_lastv[k] && m_lasti[k] == int'(idx))) begin
                            old = m_score[k];
                            m_score[k] = old + 10 * p_pts(k);
                            if (m_score[k] > 9999) m_score[k] = 9999;
                            m_dots[k]--;
                            m_lastv[k] = 1'b1;
                            m_lasti[k] = int'(idx);
                            if (EXTRA && !m_award[k] && old < 1000 && m_score[k] >= 1000) begin
                                m_award[k] = 1'b1;
                                if (m_lives[k] < 3) m_lives[k]++;
                            end
                            if (m_dots[k] == 0) begin
                                m_state[k] = 2; m_cnt[k] = 0; emptied = 1'b1;
                            end
                        end
                        if (pc && !emptied) begin
                            m_lives[k]--;
                            if (m_lives[k] == 0) m_state[k] = 3;
                        end
                    end
                    2: begin
                        m_cnt[k]++;
                        if (m_cnt[k] == p_clr(k)) begin
                            m_state[k] = 1; m_dots[k] = p_total(k); m_reload[k] = 1'b1;
                            m_level[k] = (m_level[k] < 15) ? m_level[k] + 1 : 15;
                            m_lastv[k] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic e, input int i, input logic c);
        rst = r; st = s; ev = e; idx = 10'(i); pc = c;
        @(posedge clk);
        model_step();
        #1;
        if (b_rl) rl_cnt++;
        rst = 1'b0; st = 1'b0; ev = 1'b0; pc = 1'b0;
    endtask

    task automatic cmp(input int k, input int sc, input int dt, input int lv, input int lvl,
                       input int gs, input int rl);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, "_score"}, sc, to_bcd(m_score[k]));
        chk({p, "_dots"}, dt, m_dots[k]);
        chk({p, "_lives"}, lv, m_lives[k]);
        chk({p, "_level"}, lvl, m_level[k]);
        chk({p, "_state"}, gs, m_state[k]);
        chk({p, "_reload"}, rl, int'(m_reload[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, a_score, a_dots, a_lives, a_level, a_state, a_rl);
            cmp(1, b_score, b_dots, b_lives, b_level, b_state, b_rl);
        end
    end

    initial begin
        // reset values
        tick(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_state", a_state, 0);
        chk("rst_score", a_score, 0);
        chk("rst_dots", a_dots, 150);
        chk("rst_lives", a_lives, 3);
        chk("rst_level", a_level, 1);
        chk("rst_reload", a_rl, 0);
        chk("rst_b_dots", b_dots, 2);

        // start, then three distinct eats
        tick(0, 1, 0, 0, 0);
        chk("start_reload", a_rl, 1);
        chk("start_state", a_state, 1);
        tick(0, 0, 1, 5, 0);
        tick(0, 0, 1, 6, 0);
        tick(0, 0, 1, 7, 0);
        chk("eat3_score", a_score, 16'h0030);
        chk("eat3_dots", a_dots, 147);
        chk("eat3_state", a_state, 1);
        chk("b_empty_clear", b_state, 2);

        // repeated index counted once
        tick(0, 0, 1, 9, 0);
        tick(0, 0, 1, 9, 0);
        chk("dup_score", a_score, 16'h0040);
        chk("dup_dots", a_dots, 146);

        // last dot together with a catch: clear wins, then level advance
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 2, 1);
        chk("clr_b_state", b_state, 2);
        chk("clr_b_lives", b_lives, 2);
        chk("clr_a_lives", a_lives, 2);
        rl_cnt = 0;
        for (int n = 0; n < B_CLR + 1; n++) tick(0, 0, 0, 0, 0);
        chk("clr_b_level", b_level, 2);
        chk("clr_b_dots", b_dots, 2);
        chk("clr_b_state2", b_state, 1);
        chk("clr_reload_cnt", rl_cnt, 1);

        // run out of lives, eats ignored in OVER, restart
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 3, 0);
        for (int n = 0; n < 3; n++) tick(0, 0, 0, 0, 1);
        chk("over_lives", a_lives, 0);
        chk("over_state", a_state, 3);
        tick(0, 0, 1, 4, 0);
        chk("over_eat_score", a_score, 16'h0010);
        chk("over_eat_dots", a_dots, 149);
        tick(0, 1, 0, 0, 0);
        chk("restart_score", a_score, 0);
        chk("restart_lives", a_lives, 3);

        // long eating run: 1000 crossing, score and level saturation
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        for (int n = 0; n < 600; n++) tick(0, 0, 1, n, 0);
        chk("sat_b_score", b_score, 16'h9999);
        chk("sat_b_level", b_level, 15);
        chk("sat_b_lives", b_lives, EXTRA ? 3 : 2);
        chk("sat_a_lives", a_lives, 3);

        // reset in the middle of CLEAR
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 2, 0);
        tick(0, 0, 0, 0, 0);
        chk("midclr_pre", b_state, 2);
        tick(1, 0, 0, 0, 0);
        chk("midclr_state", b_state, 0);
        chk("midclr_reload", b_rl, 0);
        chk("midclr_dots", b_dots, 2);
        chk("midclr_score", b_score, 0);
        chk("midclr_level", b_level, 1);
        tick(0, 0, 0, 0, 0);
        chk("midclr_reload2", b_rl, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++)
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) == 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter DOT_TOTAL, default 150: number of edible dots in a freshly loaded maze.
REQ-002 Parameter DOT_POINTS, default 1: tens-digit increment per dot, range 1..9 (1 = 10 points).
REQ-003 Parameter CLEAR_CYCLES, default 120: number of cycles spent in CLEAR before the next level starts.
REQ-004 Parameter START_LIVES, default 3: lives at game start, range 1..3.
REQ-005 clk  in  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that starts a game.
REQ-008 eat_valid  in  1  pulse from the player control stage: a dot was eaten this cycle.
REQ-009 eat_tile_idx  in  10  tile index of the eaten dot, valid with eat_valid.
REQ-010 player_caught  in  1  pulse from ghost collision logic.
REQ-011 score_bcd  out  16  four packed BCD digits; [3:0] is the ones digit.
REQ-012 dots_left  out  8  dots remaining in the current maze.
REQ-013 lives  out  2  remaining lives.
REQ-014 level  out  4  current level number, starting at 1.
REQ-015 game_state  out  2  encoding: IDLE=0, PLAYING=1, CLEAR=2, OVER=3.
REQ-016 dot_reload  out  1  one-cycle pulse that tells the tilemap owner to restore all dots.

Function
REQ-017 State machine transitions:
- IDLE --start--> PLAYING
- PLAYING --last dot eaten--> CLEAR
- PLAYING --lives reach 0--> OVER
- CLEAR --CLEAR_CYCLES elapsed--> PLAYING
- OVER --start--> PLAYING
REQ-018 On start from IDLE or OVER:
- score_bcd=0, dots_left=DOT_TOTAL, lives=START_LIVES, level=1.
- dot_reload pulses in the same cycle as the transition.
REQ-019 eat_valid is accepted only in PLAYING, and only when eat_tile_idx differs from the last accepted index. Rejected eats change nothing.
REQ-020 An accepted eat has the following effects, with 1-cycle latency:
- DOT_POINTS is BCD-added to the tens digit, with carry ripple into hundreds and thousands.
- dots_left decrements by 1.
REQ-021 Score saturates at 9999; an eat that would exceed 9999 leaves score_bcd=16'h9999.
REQ-022 An accepted eat when dots_left==1 sets dots_left=0 and enters CLEAR on the next cycle.
REQ-023 CLEAR exit behaviour:
- A counter runs 0..CLEAR_CYCLES-1; on the last count the block enters PLAYING.
- dots_left=DOT_TOTAL and level+1, saturating at 15.
- dot_reload pulses and the last-accepted index is cleared.
- score and lives are unchanged.
REQ-024 player_caught in PLAYING decrements lives; when lives==1 it sets lives=0 and enters OVER.
REQ-025 Simultaneous eat_valid and player_caught: the eat is applied first. If that eat empties the maze, CLEAR wins and the caught is ignored; otherwise both apply in the same cycle.
REQ-026 eat_valid and player_caught are ignored in IDLE, CLEAR and OVER.
REQ-027 start is ignored in PLAYING and CLEAR.

Reset
REQ-028 reset high at any edge, including mid-CLEAR or mid-game, forces the following values on the next edge:
- game_state=IDLE, score_bcd=0, dots_left=DOT_TOTAL, lives=START_LIVES, level=1.
- dot_reload=0, CLEAR counter=0, last-accepted index cleared.
REQ-029 reset has priority over every other input in the same cycle.

Configuration
REQ-030 Macro EXTRA_LIFE_EN, when defined, enables the extra-life award:
- The first accepted eat that moves score from below 1000 to 1000 or above awards +1 life, saturating at 3.
- At most one award per game; the award flag clears on start and on reset.
REQ-031 Without EXTRA_LIFE_EN, lives change only through start, reset and player_caught, and no award logic is synthesised.

Structure
REQ-032 Shared package pacman_pkg holds:
- the game_state encoding constants;
- TILE_IDX_W=10;
- BCD_DIGITS=4;
- the default DOT_TOTAL.
REQ-033 The BCD add-with-carry is a sub-module named bcd_digit_add, instantiated once per score digit from tens upward.

Verification
REQ-034 reset, start, 3 eats at idx 5,6,7 -> score_bcd=16'h0030, dots_left=147, game_state=PLAYING.
REQ-035 eat idx 9 on two consecutive cycles -> counted once: score +10, dots_left -1.
REQ-036 DOT_TOTAL=2, eat idx 1 then idx 2 asserted together with player_caught -> CLEAR entered, lives unchanged. After CLEAR_CYCLES: level=2, dots_left=2, one dot_reload pulse.
REQ-037 START_LIVES=3, three player_caught pulses -> lives=0, game_state=OVER, later eats ignored; then start -> score_bcd=0, lives=3.
REQ-038 Preload score 16'h0995, eat -> 16'h1005, and lives+1 only when EXTRA_LIFE_EN is defined; preload 16'h9995, eat -> 16'h9999.
REQ-039 reset asserted mid-CLEAR -> IDLE with all reset values on the next edge, and no dot_reload pulse.
